// File: rtl/flag_int_unit.sv
// Flag and interrupt-request unit for the RAT CPU: C/Z/I flags, the shadow C/Z pair,
// and a synchronised, edge-detected, latched external interrupt request.
module flag_int_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic INT_IN,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT,
    output logic INT_PENDING
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} pend_state_t;

    logic c_reg, c_next;
    logic z_reg, z_next;
    logic i_reg, i_next;
    logic shad_c_reg, shad_c_next;
    logic shad_z_reg, shad_z_next;
    logic src_c, src_z;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] valid_reg;
    logic                   sync_d_reg;
    logic                   armed_reg;
    logic                   sync_out;
    logic                   sync_valid;
    logic                   rise;
    pend_state_t            state_reg;

    // ---------------- flags and shadow ----------------
    assign src_c = FLG_LD_SEL ? shad_c_reg : ALU_C;
    assign src_z = FLG_LD_SEL ? shad_z_reg : ALU_Z;

    always_comb begin
        c_next = c_reg;
        if (FLG_C_CLR)
            c_next = 1'b0;
        else if (FLG_C_SET)
            c_next = 1'b1;
        else if (FLG_C_LD)
            c_next = src_c;

        z_next = z_reg;
        if (FLG_Z_LD)
            z_next = src_z;

        // Shadow always captures the pre-edge flags, so LD_SEL + SHAD_LD swaps.
        shad_c_next = shad_c_reg;
        shad_z_next = shad_z_reg;
        if (FLG_SHAD_LD) begin
            shad_c_next = c_reg;
            shad_z_next = z_reg;
        end

        i_next = i_reg;
        if (I_CLR)
            i_next = 1'b0;
        else if (I_SET)
            i_next = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            c_reg      <= 1'b0;
            z_reg      <= 1'b0;
            i_reg      <= 1'b0;
            shad_c_reg <= 1'b0;
            shad_z_reg <= 1'b0;
        end else begin
            c_reg      <= c_next;
            z_reg      <= z_next;
            i_reg      <= i_next;
            shad_c_reg <= shad_c_next;
            shad_z_reg <= shad_z_next;
        end
    end

    // ---------------- interrupt synchroniser ----------------
    // valid_reg tracks which stages hold a real INT_IN sample rather than reset zeros.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (RESET) begin
                        sync_reg[gi]  <= 1'b0;
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi]  <= INT_IN;
                        valid_reg[gi] <= 1'b1;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge CLK) begin
                    if (RESET) begin
                        sync_reg[gi]  <= 1'b0;
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        sync_reg[gi]  <= sync_reg[gi-1];
                        valid_reg[gi] <= valid_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign sync_out   = sync_reg[SYNC_STAGES-1];
    assign sync_valid = valid_reg[SYNC_STAGES-1];

    // An edge only counts once a genuine low has been seen since reset, so a level
    // held across reset cannot fake a rising edge out of the cleared chain.
    assign rise = sync_out & ~sync_d_reg & armed_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_d_reg <= 1'b0;
            armed_reg  <= 1'b0;
        end else begin
            sync_d_reg <= sync_out;
            if (sync_valid && !sync_out)
                armed_reg <= 1'b1;
        end
    end

    // ---------------- pending request FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: if (rise) state_reg <= PEND;
                PEND: if (INT_ACK && !rise) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign C_FLAG      = c_reg;
    assign Z_FLAG      = z_reg;
    assign I_FLAG      = i_reg;
    assign INT_PENDING = (state_reg == PEND);
    assign INT         = INT_PENDING & i_reg;

endmodule

// File: tb/tb_flag_int_unit.sv
// Directed testbench for flag_int_unit with hand-computed expectations.
module tb_flag_int_unit;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic INT_IN = 1'b0;
    logic ALU_C = 1'b0, ALU_Z = 1'b0;
    logic FLG_C_SET = 1'b0, FLG_C_CLR = 1'b0, FLG_C_LD = 1'b0, FLG_Z_LD = 1'b0;
    logic FLG_LD_SEL = 1'b0, FLG_SHAD_LD = 1'b0;
    logic I_SET = 1'b0, I_CLR = 1'b0, INT_ACK = 1'b0;
    logic C_FLAG, Z_FLAG, I_FLAG, INT, INT_PENDING;

    int checks = 0;
    int errors = 0;

    flag_int_unit #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .INT_IN(INT_IN),
        .ALU_C(ALU_C), .ALU_Z(ALU_Z),
        .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD),
        .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .INT(INT), .INT_PENDING(INT_PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_strobes();
        FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
        FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
        ALU_C = 0; ALU_Z = 0;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("check %-22s observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic c, input logic z, input logic i,
                           input logic it, input logic p);
        chk({tag, ".C"}, C_FLAG, c);
        chk({tag, ".Z"}, Z_FLAG, z);
        chk({tag, ".I"}, I_FLAG, i);
        chk({tag, ".INT"}, INT, it);
        chk({tag, ".PEND"}, INT_PENDING, p);
    endtask

    initial begin
        // Reset
        RESET = 1; tick(); tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        RESET = 0;
        repeat (4) tick();

        // Flag priority
        clear_strobes(); FLG_C_SET = 1; tick();
        chk("c_set", C_FLAG, 1);
        clear_strobes(); FLG_C_SET = 1; FLG_C_CLR = 1; tick();
        chk("c_clr_wins", C_FLAG, 0);
        clear_strobes(); FLG_C_LD = 1; FLG_Z_LD = 1; ALU_C = 1; ALU_Z = 1; tick();
        chk("ld_alu_c", C_FLAG, 1);
        chk("ld_alu_z", Z_FLAG, 1);

        // Build C=1,Z=0 with shadow 0/1
        clear_strobes(); FLG_C_CLR = 1; tick();
        chk("prep_c0", C_FLAG, 0);
        clear_strobes(); FLG_SHAD_LD = 1; FLG_C_SET = 1; FLG_Z_LD = 1; ALU_Z = 0; tick();
        chk("prep_c1", C_FLAG, 1);
        chk("prep_z0", Z_FLAG, 0);

        // Swap: flags take old shadow (0,1), shadow takes old flags (1,0)
        clear_strobes(); FLG_SHAD_LD = 1; FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        ALU_C = 1; ALU_Z = 0; tick();
        chk("swap_c", C_FLAG, 0);
        chk("swap_z", Z_FLAG, 1);
        clear_strobes(); FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; tick();
        chk("shad_c_readback", C_FLAG, 1);
        chk("shad_z_readback", Z_FLAG, 0);

        // Interrupt latency: INT_IN high before edge 1, request after edge 3
        clear_strobes(); I_SET = 1; tick();
        chk("i_set", I_FLAG, 1);
        clear_strobes(); INT_IN = 1; tick();
        chk("lat_e1_int", INT, 0);
        INT_IN = 0; tick();
        chk("lat_e2_int", INT, 0);
        tick();
        chk("lat_e3_int", INT, 1);
        chk("lat_e3_pend", INT_PENDING, 1);
        tick(); tick();
        chk("lat_e5_int", INT, 1);
        INT_ACK = 1; tick(); INT_ACK = 0;
        chk("ack_int", INT, 0);
        chk("ack_pend", INT_PENDING, 0);

        // Masking
        I_CLR = 1; tick(); I_CLR = 0;
        chk("i_clr", I_FLAG, 0);
        INT_IN = 1; tick(); INT_IN = 0; tick(); tick();
        chk("mask_pend", INT_PENDING, 1);
        chk("mask_int", INT, 0);
        I_SET = 1; tick(); I_SET = 0;
        chk("unmask_int", INT, 1);
        I_SET = 1; I_CLR = 1; tick(); I_SET = 0; I_CLR = 0;
        chk("iclr_wins_i", I_FLAG, 0);
        chk("iclr_wins_int", INT, 0);
        chk("iclr_wins_pend", INT_PENDING, 1);
        INT_ACK = 1; tick(); INT_ACK = 0;
        chk("mask_ack_pend", INT_PENDING, 0);
        INT_ACK = 1; tick(); INT_ACK = 0;
        chk("ack_idle_pend", INT_PENDING, 0);

        // Edge and ACK in the same cycle: edge wins
        I_SET = 1; tick(); I_SET = 0;
        INT_IN = 1; tick(); INT_IN = 0; tick(); tick();
        chk("sim_first_pend", INT_PENDING, 1);
        INT_IN = 1; tick(); INT_IN = 0; tick();
        INT_ACK = 1; tick(); INT_ACK = 0;
        chk("sim_edge_wins", INT_PENDING, 1);
        chk("sim_edge_int", INT, 1);
        INT_ACK = 1; tick(); INT_ACK = 0;
        chk("sim_ack_pend", INT_PENDING, 0);

        // Held level: exactly one request
        INT_IN = 1;
        for (int i = 1; i <= 20; i++) begin
            INT_ACK = (i == 5);
            tick();
            if (i == 3) chk("held_pend", INT_PENDING, 1);
            if (i >= 5) chk($sformatf("held_int_%0d", i), INT, 0);
        end
        INT_ACK = 0;

        // Reset mid-operation with request pending
        INT_IN = 0; repeat (3) tick();
        INT_IN = 1; repeat (3) tick();
        chk("pre_rst_pend", INT_PENDING, 1);
        FLG_C_SET = 1; tick(); FLG_C_SET = 0;
        chk("pre_rst_c", C_FLAG, 1);
        chk("pre_rst_int", INT, 1);
        RESET = 1; tick(); RESET = 0;
        chk_all("mid_rst", 0, 0, 0, 0, 0);
        repeat (6) tick();
        chk("held_after_rst", INT_PENDING, 0);
        INT_IN = 0; repeat (3) tick();
        chk("low_after_rst", INT_PENDING, 0);
        INT_IN = 1; repeat (3) tick();
        chk("retrigger_pend", INT_PENDING, 1);
        chk("retrigger_int", INT, 0);
        INT_IN = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
